// File: rtl/nixie_scan_decoder_pkg.sv
// rtl/nixie_scan_decoder_pkg.sv - shared constants and state encoding for the nixie scan decoder
//
// Purpose: widths of a BCD digit and of the cathode vector, plus the scan FSM
//          state encoding shared by the top and its decoder.
// Ports:   none (package).
package nixie_scan_decoder_pkg;

  localparam int BCD_W = 4;   // bits per BCD digit
  localparam int LINES = 10;  // cathode lines, one per decimal value

  // Scan FSM states kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BLANK = 2'd1;
  localparam state_t ST_SHOW  = 2'd2;

endpackage

// File: rtl/bcd_to_onehot.sv
// rtl/bcd_to_onehot.sv - combinational 4-bit BCD to 1-of-10 cathode decoder
//
// Purpose: inverse of the decimal-to-BCD encoder. Codes 0-9 light exactly one
//          line; codes 10-15 light nothing and drop the valid flag.
// Ports:   code  - 4-bit BCD input
//          line  - 10-bit one-hot output, bit k set for value k
//          valid - high when code <= 9
module bcd_to_onehot
  import nixie_scan_decoder_pkg::*;
(
  input  logic [BCD_W-1:0] code,
  output logic [LINES-1:0] line,
  output logic             valid
);

  always_comb begin
    valid = (code <= 4'd9);
    line  = '0;
    if (valid) begin
      line = LINES'(1) << code;
    end
  end

endmodule

// File: rtl/nixie_scan_decoder.sv
// rtl/nixie_scan_decoder.sv - multiplexed BCD-to-cathode display scanner
//
// Purpose: time-multiplexes DIGITS packed BCD digits onto a 10-line cathode bus
//          with a one-hot digit select, a blanking gap before each digit and a
//          frame-synchronous shadow register so a frame never tears.
// Ports:   clk, rst_n     - clock, asynchronous active-low reset
//          enable         - scan enable; low forces the display off
//          load, bcd_in   - capture packed BCD (digit 0 in bits [3:0])
//          line           - one-hot cathode vector
//          sel            - one-hot digit select
//          err            - invalid code (10-15) in the current SHOW slot
//          frame_start    - one-cycle pulse on the first BLANK of each frame
module nixie_scan_decoder
  import nixie_scan_decoder_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DWELL  = 1000,
  parameter int BLANK  = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] bcd_in,
  output logic [LINES-1:0]        line,
  output logic [DIGITS-1:0]       sel,
  output logic                    err,
  output logic                    frame_start
);

  localparam int MAXC = (BLANK > DWELL) ? BLANK : DWELL;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int AW   = BCD_W * DIGITS;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     counter_q, counter_d;
  logic [AW-1:0]     shadow_q, shadow_d;
  logic [AW-1:0]     active_q, active_d;
  logic              pending_q, pending_d;
  logic [LINES-1:0]  line_q, line_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic              err_q, err_d;
  logic              frame_start_q, frame_start_d;

  logic [BCD_W-1:0]  cur_code;
  logic [LINES-1:0]  dec_line;
  logic              dec_valid;

  // Digit mux. Whenever the next state is SHOW, idx and active hold their
  // current values (idx only advances on SHOW->BLANK, active only loads on a
  // frame start), so the registered copies select the right digit.
  always_comb begin
    cur_code = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_code = active_q[i*BCD_W +: BCD_W];
      end
    end
  end

  bcd_to_onehot u_dec (
    .code  (cur_code),
    .line  (dec_line),
    .valid (dec_valid)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    counter_d     = counter_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    pending_d     = pending_q;
    frame_start_d = 1'b0;

    if (load) begin
      shadow_d  = bcd_in;
      pending_d = 1'b1;
    end

    if (!enable) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      counter_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d       = ST_BLANK;
          idx_d         = '0;
          counter_d     = '0;
          frame_start_d = 1'b1;
        end
        ST_BLANK: begin
          if (counter_q == BLANK_LAST) begin
            state_d   = ST_SHOW;
            counter_d = '0;
          end else begin
            counter_d = counter_q + CW'(1);
          end
        end
        ST_SHOW: begin
          if (counter_q == DWELL_LAST) begin
            state_d   = ST_BLANK;
            counter_d = '0;
            if (idx_q == IDX_LAST) begin
              idx_d         = '0;
              frame_start_d = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            counter_d = counter_q + CW'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          counter_d = '0;
        end
      endcase
    end

    // Frame boundary: a load on this very edge goes straight to active,
    // otherwise a pending shadow value is promoted.
    if (frame_start_d) begin
      if (load) begin
        active_d  = bcd_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end

    line_d = '0;
    sel_d  = '0;
    err_d  = 1'b0;
    if (state_d == ST_SHOW) begin
      line_d = dec_line;
      err_d  = ~dec_valid;
      for (int i = 0; i < DIGITS; i++) begin
        sel_d[i] = (idx_q == IW'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      counter_q     <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      line_q        <= '0;
      sel_q         <= '0;
      err_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      counter_q     <= counter_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      line_q        <= line_d;
      sel_q         <= sel_d;
      err_q         <= err_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign line        = line_q;
  assign sel         = sel_q;
  assign err         = err_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_nixie_scan_decoder.sv
// tb/tb_nixie_scan_decoder.sv - self-checking bench for nixie_scan_decoder
module tb_nixie_scan_decoder;

  localparam int ND     = 4;
  localparam int DW     = 4;
  localparam int BL     = 2;
  localparam int SLOT   = BL + DW;
  localparam int PERIOD = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] bcd_in;
  logic [9:0]  line;
  logic [3:0]  sel;
  logic        err;
  logic        frame_start;

  logic        rst1_n;
  logic        en1;
  logic        load1;
  logic [3:0]  bcd1;
  logic [9:0]  line1;
  logic [0:0]  sel1;
  logic        err1;
  logic        fs1;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: time since the enabling edge plus frame contents.
  bit          m_run;
  int          m_t;
  logic [15:0] m_act;
  logic [15:0] m_shadow;
  bit          m_pend;

  always #5 clk = ~clk;

  nixie_scan_decoder #(.DIGITS(ND), .DWELL(DW), .BLANK(BL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .load        (load),
    .bcd_in      (bcd_in),
    .line        (line),
    .sel         (sel),
    .err         (err),
    .frame_start (frame_start)
  );

  nixie_scan_decoder #(.DIGITS(1), .DWELL(1), .BLANK(1)) dut1 (
    .clk         (clk),
    .rst_n       (rst1_n),
    .enable      (en1),
    .load        (load1),
    .bcd_in      (bcd1),
    .line        (line1),
    .sel         (sel1),
    .err         (err1),
    .frame_start (fs1)
  );

  function automatic logic [15:0] got_v();
    return {line, sel, err, frame_start};
  endfunction

  function automatic logic [15:0] exp_v();
    int slot, w;
    logic [3:0] code;
    logic [9:0] l;
    logic [3:0] s;
    if (!m_run) return 16'h0;
    slot = m_t / SLOT;
    w    = m_t % SLOT;
    if (w < BL) return {10'b0, 4'b0, 1'b0, (m_t == 0)};
    code = m_act[slot*4 +: 4];
    l = (code < 10) ? (10'd1 << code) : 10'd0;
    s = 4'd1 << slot;
    return {l, s, (code > 9), 1'b0};
  endfunction

  task automatic model_edge(input logic e, input logic l, input logic [15:0] b);
    bit fs = 0;
    if (!e) begin
      m_run = 0;
      m_t   = 0;
    end else if (!m_run) begin
      m_run = 1;
      m_t   = 0;
      fs    = 1;
    end else begin
      m_t++;
      if (m_t == PERIOD) begin
        m_t = 0;
        fs  = 1;
      end
    end
    if (fs && l) m_act = b;
    else if (fs && m_pend) m_act = m_shadow;
    if (fs) m_pend = 0;
    if (l) begin
      m_shadow = b;
      if (!fs) m_pend = 1;
    end
  endtask

  task automatic tick(input logic e, input logic l, input logic [15:0] b);
    enable = e;
    load   = l;
    bcd_in = b;
    @(posedge clk);
    model_edge(e, l, b);
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst1_n = 1'b0;
    enable = 1'b0; load = 1'b0; bcd_in = '0;
    en1 = 1'b0; load1 = 1'b0; bcd1 = '0;
    #3;
    checks++;
    if (got_v() !== 16'h0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0000", got_v());
    end
    @(posedge clk); #1;
    rst_n = 1'b1; rst1_n = 1'b1;
    m_run = 0; m_t = 0; m_act = '0; m_shadow = '0; m_pend = 0;
    tick(0, 0, 16'h0);
    checks++;
    if (got_v() !== 16'h0) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=0000", got_v());
    end
  endtask

  task automatic test_basic_scan();
    int fs_seen = 0;
    for (int i = 0; i < 2 * PERIOD + 3; i++) begin
      tick(1, 0, 16'h0);
      fs_seen += frame_start;
      checks++;
      if (got_v() !== exp_v()) begin
        failures++;
        $display("FAIL basic_scan t=%0d got=%h exp=%h", m_t, got_v(), exp_v());
      end
    end
    checks++;
    if (fs_seen !== 3) begin
      failures++;
      $display("FAIL basic_fs_count got=%0d exp=3", fs_seen);
    end
  endtask

  task automatic test_load_midframe();
    for (int i = 0; i < PERIOD && m_t != 8; i++) tick(1, 0, 16'h0);
    tick(1, 1, 16'h9305);
    for (int i = 0; i < 2 * PERIOD; i++) begin
      tick(1, 0, 16'h0);
      checks++;
      if (got_v() !== exp_v()) begin
        failures++;
        $display("FAIL load_midframe t=%0d got=%h exp=%h", m_t, got_v(), exp_v());
      end
    end
  endtask

  task automatic test_last_wins();
    tick(1, 1, 16'h1111);
    tick(1, 1, 16'h2222);
    for (int i = 0; i < PERIOD && m_t != PERIOD - 1; i++) tick(1, 0, 16'h0);
    tick(1, 1, 16'h7777);
    checks++;
    if (frame_start !== 1'b1) begin
      failures++;
      $display("FAIL last_wins_fs got=%b exp=1", frame_start);
    end
    for (int i = 0; i < PERIOD; i++) begin
      tick(1, 0, 16'h0);
      checks++;
      if (got_v() !== exp_v()) begin
        failures++;
        $display("FAIL last_wins t=%0d got=%h exp=%h", m_t, got_v(), exp_v());
      end
    end
  endtask

  task automatic test_invalid();
    int err_cnt = 0;
    tick(1, 1, 16'h00C0);
    for (int i = 0; i < PERIOD && m_t != PERIOD - 1; i++) tick(1, 0, 16'h0);
    for (int i = 0; i < PERIOD; i++) begin
      tick(1, 0, 16'h0);
      err_cnt += err;
      checks++;
      if (got_v() !== exp_v()) begin
        failures++;
        $display("FAIL invalid t=%0d got=%h exp=%h", m_t, got_v(), exp_v());
      end
    end
    checks++;
    if (err_cnt !== DW) begin
      failures++;
      $display("FAIL invalid_err_cycles got=%0d exp=%0d", err_cnt, DW);
    end
  endtask

  task automatic test_disable();
    for (int i = 0; i < PERIOD && m_t != 2 * SLOT + BL + 1; i++) tick(1, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick(0, (i == 1), 16'h4321);
      checks++;
      if (got_v() !== 16'h0) begin
        failures++;
        $display("FAIL disable_off got=%h exp=0000", got_v());
      end
    end
    for (int i = 0; i < PERIOD + 4; i++) begin
      tick(1, 0, 16'h0);
      checks++;
      if (got_v() !== exp_v()) begin
        failures++;
        $display("FAIL reenable t=%0d got=%h exp=%h", m_t, got_v(), exp_v());
      end
    end
  endtask

  task automatic test_random();
    logic        e, l;
    logic [15:0] b;
    for (int i = 0; i < 600; i++) begin
      e = ($urandom_range(0, 59) != 0);
      l = ($urandom_range(0, 14) == 0);
      b = 16'($urandom);
      tick(e, l, b);
      checks++;
      if (got_v() !== exp_v()) begin
        failures++;
        $display("FAIL random i=%0d t=%0d got=%h exp=%h", i, m_t, got_v(), exp_v());
      end
    end
  endtask

  task automatic test_single_digit();
    logic [12:0] g, x;
    en1 = 1'b1; load1 = 1'b1; bcd1 = 4'h3;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      load1 = 1'b0;
      g = {line1, sel1, err1, fs1};
      x = (k % 2 == 0) ? 13'b0000000000_0_0_1 : 13'b0000001000_1_0_0;
      checks++;
      if (g !== x) begin
        failures++;
        $display("FAIL single_digit k=%0d got=%h exp=%h", k, g, x);
      end
    end
    // Last sample (k=9) is a SHOW cycle; pull reset between clock edges.
    #2 rst1_n = 1'b0;
    #1;
    checks++;
    if ({line1, sel1, err1, fs1} !== 13'h0) begin
      failures++;
      $display("FAIL single_async_reset got=%h exp=0000", {line1, sel1, err1, fs1});
    end
    @(posedge clk); #1;
    rst1_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_load_midframe();
    test_last_wins();
    test_invalid();
    test_disable();
    test_random();
    test_single_digit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
